// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline hazard controller.
package pipe_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } fsm_state_t;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    localparam int REG_W_DEF = 5;

    function automatic logic src_hit(input logic used, input logic [31:0] rs, input logic [31:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/mem_timeout_watchdog.sv
// Counts consecutive memory wait cycles and raises a sticky timeout flag.
module mem_timeout_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_stall,
    output logic mem_timeout
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WLIM    = WCW'(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WLIM_M1 = WCW'(MEM_TIMEOUT - 1);

    logic [WCW-1:0] wcnt;

    // The flag sets on the same edge that wcnt reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt        <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (!mem_stall)
                wcnt <= '0;
            else if (wcnt != WLIM)
                wcnt <= wcnt + 1'b1;
            if (mem_stall && (wcnt == WLIM || wcnt == WLIM_M1))
                mem_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hold/clear generation for PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W         = REG_W_DEF,
    parameter int MULDIV_CYCLES = 4,
    parameter int MEM_TIMEOUT   = 255,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_start,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             hold_idex,
    output logic             hold_exmem,
    output logic             hold_memwb,
    output logic             clear_ifid,
    output logic             clear_idex,
    output logic             clear_exmem,
    output logic             clear_memwb,
    output logic             muldiv_done,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MDW_RAW = $clog2(MULDIV_CYCLES) + 1;
    localparam int MDW     = (MDW_RAW < 4) ? 4 : MDW_RAW;
    localparam logic [MDW-1:0] MD_LOAD = MDW'((MULDIV_CYCLES > 1) ? MULDIV_CYCLES - 2 : 0);

    fsm_state_t     state, state_nx;
    logic [MDW-1:0] mdcnt, mdcnt_nx;
    logic           mem_stall;
    logic           load_use;
    logic           muldiv_stall;
    logic           done_raw;

    logic [STG_MEMWB:STG_PC]   hold;
    logic [STG_MEMWB:STG_IFID] clr;

    assign mem_stall = mem_req & ~mem_ack;
    assign load_use  = ex_memread && (ex_rd != '0) &&
                       (src_hit(id_rs1_used, 32'(id_rs1), 32'(ex_rd)) ||
                        src_hit(id_rs2_used, 32'(id_rs2), 32'(ex_rd)));

    // A memory wait freezes the mul/div sequencing entirely.
    always_comb begin
        state_nx     = state;
        mdcnt_nx     = mdcnt;
        muldiv_stall = 1'b0;
        done_raw     = 1'b0;
        case (state)
            RUN: begin
                if (ex_muldiv_start && !mem_stall) begin
                    if (MULDIV_CYCLES > 1) begin
                        muldiv_stall = 1'b1;
                        mdcnt_nx     = MD_LOAD;
                        state_nx     = MULDIV;
                    end else begin
                        done_raw = 1'b1;
                    end
                end
            end
            MULDIV: begin
                if (!mem_stall) begin
                    if (mdcnt != '0) begin
                        muldiv_stall = 1'b1;
                        mdcnt_nx     = mdcnt - 1'b1;
                    end else begin
                        done_raw = 1'b1;
                        state_nx = RUN;
                    end
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        hold = '0;
        clr  = '0;
        if (rst) begin
            clr = '1;
        end else if (mem_stall) begin
            hold = '1;
        end else if (muldiv_stall) begin
            hold[STG_PC]   = 1'b1;
            hold[STG_IFID] = 1'b1;
            hold[STG_IDEX] = 1'b1;
            clr[STG_EXMEM] = 1'b1;
        end else if (ex_branch_taken && state == RUN) begin
            clr[STG_IFID] = 1'b1;
            clr[STG_IDEX] = 1'b1;
        end else if (load_use) begin
            hold[STG_PC]   = 1'b1;
            hold[STG_IFID] = 1'b1;
            clr[STG_IDEX]  = 1'b1;
        end
    end

    assign hold_pc     = hold[STG_PC];
    assign hold_ifid   = hold[STG_IFID];
    assign hold_idex   = hold[STG_IDEX];
    assign hold_exmem  = hold[STG_EXMEM];
    assign hold_memwb  = hold[STG_MEMWB];
    assign clear_ifid  = clr[STG_IFID];
    assign clear_idex  = clr[STG_IDEX];
    assign clear_exmem = clr[STG_EXMEM];
    assign clear_memwb = clr[STG_MEMWB];
    assign muldiv_done = done_raw & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            mdcnt        <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nx;
            mdcnt <= mdcnt_nx;
            if (hold_pc && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    mem_timeout_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .mem_stall  (mem_stall),
        .mem_timeout(mem_timeout)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int N     = 4;
    localparam int T     = 3;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic id_rs1_used, id_rs2_used, ex_memread, ex_branch_taken, ex_muldiv_start, mem_req, mem_ack;
    logic hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb;
    logic clear_ifid, clear_idex, clear_exmem, clear_memwb, muldiv_done, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: mul/div progress as elapsed working cycles
    bit m_busy = 0;
    int m_elapsed = 0;
    int m_run = 0;
    bit m_to = 0;
    int m_cnt = 0;

    pipe_hazard_ctrl #(
        .REG_W(REG_W), .MULDIV_CYCLES(N), .MEM_TIMEOUT(T), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .ex_muldiv_start(ex_muldiv_start), .mem_req(mem_req), .mem_ack(mem_ack),
        .hold_pc(hold_pc), .hold_ifid(hold_ifid), .hold_idex(hold_idex),
        .hold_exmem(hold_exmem), .hold_memwb(hold_memwb),
        .clear_ifid(clear_ifid), .clear_idex(clear_idex), .clear_exmem(clear_exmem),
        .clear_memwb(clear_memwb), .muldiv_done(muldiv_done), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] dut_vec();
        return {hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb,
                clear_ifid, clear_idex, clear_exmem, clear_memwb, muldiv_done};
    endfunction

    // One clock: compare combinational and registered outputs, then advance the model.
    task automatic cycle(input string tag);
        bit ms, lu, active, mds, dn;
        bit hp, hif, hie, hxm, hmw, cif, cie, cxm, cmw;
        int k;
        @(negedge clk);
        ms = mem_req && !mem_ack;
        lu = ex_memread && ex_rd != 0 &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        active = m_busy || ex_muldiv_start;
        k = m_elapsed + 1;
        {hp, hif, hie, hxm, hmw, cif, cie, cxm, cmw} = '0;
        mds = 0;
        dn = 0;
        if (rst) begin
            {cif, cie, cxm, cmw} = 4'b1111;
        end else if (ms) begin
            {hp, hif, hie, hxm, hmw} = 5'b11111;
        end else begin
            mds = active && k < N;
            dn  = active && k >= N;
            if (mds) begin
                {hp, hif, hie, cxm} = 4'b1111;
            end else if (ex_branch_taken && !m_busy) begin
                {cif, cie} = 2'b11;
            end else if (lu) begin
                {hp, hif, cie} = 3'b111;
            end
        end
        chk({tag, ".ctl"}, 64'(dut_vec()), 64'({hp, hif, hie, hxm, hmw, cif, cie, cxm, cmw, dn}));
        chk({tag, ".tmo"}, 64'(mem_timeout), 64'(m_to));
        chk({tag, ".cnt"}, 64'(stall_cycles), 64'(m_cnt));
        if (rst) begin
            m_busy = 0;
            m_elapsed = 0;
        end else if (!ms && active) begin
            if (k < N) begin
                m_busy = 1;
                m_elapsed = k;
            end else begin
                m_busy = 0;
                m_elapsed = 0;
            end
        end
        m_run = (rst || !ms) ? 0 : m_run + 1;
        if (rst) m_to = 0;
        else if (m_run >= T) m_to = 1;
        if (rst) m_cnt = 0;
        else if (hp && m_cnt < CMAX) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 0; id_rs2_used = 0; ex_memread = 0; ex_branch_taken = 0;
        ex_muldiv_start = 0; mem_req = 0; mem_ack = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst_clears", 64'({clear_ifid, clear_idex, clear_exmem, clear_memwb}), 64'hF);
        chk("rst_holds", 64'({hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb}), 64'h0);
        cycle("rst0");
        cycle("rst1");
        rst = 0;
        #1;
        chk("run_idle", 64'(dut_vec()), 64'h0);
        chk("run_cnt0", 64'(stall_cycles), 64'h0);
        cycle("idle");

        ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
        #1;
        chk("lu_stall", 64'({hold_pc, hold_ifid, clear_idex, clear_ifid}), 64'b1110);
        cycle("lu");
        ex_rd = 0;
        #1;
        chk("lu_x0", 64'({hold_pc, clear_idex}), 64'b00);
        cycle("lu_x0");
        ex_rd = 5; ex_branch_taken = 1;
        #1;
        chk("br_over_lu", 64'({clear_ifid, clear_idex, hold_pc}), 64'b110);
        cycle("br");
        idle_inputs();

        rst = 1;
        cycle("rst_md");
        rst = 0;
        ex_muldiv_start = 1;
        for (int i = 0; i < N; i++) begin
            #1;
            chk("md_seq", 64'({hold_pc, muldiv_done}), 64'({i < N - 1, i == N - 1}));
            cycle("md");
        end
        ex_muldiv_start = 0;
        chk("md_cnt", 64'(stall_cycles), 64'(N - 1));
        cycle("md_end");

        ex_muldiv_start = 1;
        for (int i = 0; i < N + 2; i++) begin
            mem_req = (i == 2 || i == 3);
            #1;
            chk("mdms_done", 64'(muldiv_done), 64'(i == N + 1));
            if (mem_req)
                chk("mdms_hold", 64'({hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb}), 64'h1F);
            cycle("mdms");
        end
        idle_inputs();

        rst = 1;
        cycle("rst_to");
        rst = 0;
        mem_req = 1;
        for (int i = 0; i < T; i++) begin
            cycle("to_wait");
            chk("to_flag", 64'(mem_timeout), 64'(i == T - 1));
        end
        mem_ack = 1;
        cycle("to_ack");
        chk("to_sticky", 64'(mem_timeout), 64'h1);
        idle_inputs();
        rst = 1;
        cycle("to_rst");
        chk("to_clr", 64'(mem_timeout), 64'h0);
        rst = 0;

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ack = $urandom_range(0, 1) != 0;
            ex_muldiv_start = m_busy ? 1'b1 : ($urandom_range(0, 9) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_memread = ($urandom_range(0, 2) == 0);
            ex_rd = REG_W'($urandom_range(0, 3));
            id_rs1 = REG_W'($urandom_range(0, 3));
            id_rs2 = REG_W'($urandom_range(0, 3));
            id_rs1_used = $urandom_range(0, 1) != 0;
            id_rs2_used = $urandom_range(0, 1) != 0;
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
